// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs: shared types for the memory-stage data-request controller.
//   mem_size_t   : access size encoding shared by the pipeline and the data bus
//   dreq_state_t : request FSM states
// -----------------------------------------------------------------------------
package cpu_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } dreq_state_t;

endpackage

// File: rtl/mem_dreq_if.sv
// -----------------------------------------------------------------------------
// mem_dreq_if: sram-like data bus (req / addr_ok / data_ok).
//   master : request side (the mem_dreq controller)
//   slave  : memory / bus-bridge side
// Signals:
//   data_req, data_wr, data_size, data_addr, data_wdata : request fields
//   data_addr_ok : request accepted this cycle
//   data_data_ok : read data / write response valid this cycle
//   data_rdata   : read data
// -----------------------------------------------------------------------------
interface mem_dreq_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_dreq_store_align.sv
// -----------------------------------------------------------------------------
// store_align: combinational size/alignment helper for the data request.
// Ports:
//   i_size     : access size (byte/half/word)
//   i_addr_lo  : low two bits of the effective address
//   i_wdata    : right-aligned store data
//   o_misalign : half not 2-byte aligned, or word not 4-byte aligned
//   o_wdata    : store data replicated across all byte lanes, so the memory
//                can pick its lanes from the address without shifting
// -----------------------------------------------------------------------------
module store_align
  import cpu_defs::*;
(
  input  mem_size_t   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic        o_misalign,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_misalign = 1'b0;
    o_wdata    = i_wdata;
    case (i_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: begin
        o_misalign = i_addr_lo[0];
        o_wdata    = {2{i_wdata[15:0]}};
      end
      SZ_WORD: o_misalign = |i_addr_lo;
      // Encoding 3 is never produced by decode; pass data through unchanged.
      default: o_wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_dreq.sv
// -----------------------------------------------------------------------------
// mem_dreq: memory-stage data-request controller.
// Turns a load/store in M into exactly one transaction on the sram-like data
// bus, stalls the pipeline while it is outstanding and holds the raw read word
// for the M->W register. Misaligned accesses raise adel/ades and never reach
// the bus.
//
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset
//   m_valid, m_memread, m_memwrite, m_size, m_addr, m_wdata : M-stage access
//   m_flush         : exception/eret flush of M
//   m_advance       : M->W register loads this cycle
//   m_stall         : hold M and upstream stages
//   rdata_q         : captured raw read word
//   adel, ades      : load/store address error (combinational)
//   perf_stall_cnt  : stall-cycle counter (only when DREQ_PERF_EN is defined)
//   dbus            : data bus, master side
//
// Build option: define DREQ_PERF_EN to add the perf_stall_cnt port/counter.
// -----------------------------------------------------------------------------
module mem_dreq
  import cpu_defs::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic              m_memread,
  input  logic              m_memwrite,
  input  logic [1:0]        m_size,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_wdata,
  input  logic              m_flush,
  input  logic              m_advance,
  output logic              m_stall,
  output logic [31:0]       rdata_q,
  output logic              adel,
  output logic              ades,
`ifdef DREQ_PERF_EN
  output logic [PERF_W-1:0] perf_stall_cnt,
`endif
  mem_dreq_if.master        dbus
);

  dreq_state_t r_state;
  logic        r_killed;
  logic        r_data_req;
  logic        r_data_wr;
  mem_size_t   r_data_size;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_wdata;
  logic [31:0] r_rdata_q;

  mem_size_t   w_size;
  logic        w_misalign;
  logic [31:0] w_wdata_rep;
  logic        w_access;
  logic        w_start;

  assign w_size = mem_size_t'(m_size);

  store_align u_store_align (
    .i_size     (w_size),
    .i_addr_lo  (m_addr[1:0]),
    .i_wdata    (m_wdata),
    .o_misalign (w_misalign),
    .o_wdata    (w_wdata_rep)
  );

  assign w_access = m_valid & (m_memread | m_memwrite);
  assign w_start  = w_access & ~w_misalign & ~m_flush;

  assign adel = m_valid & m_memread  & w_misalign;
  assign ades = m_valid & m_memwrite & w_misalign;

  // Stall must rise in the very cycle the access is seen in IDLE, so it is
  // decoded from the state rather than registered.
  assign m_stall = ((r_state == IDLE) & w_start) | (r_state == ADDR) | (r_state == DATA);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_killed     <= 1'b0;
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= SZ_BYTE;
      r_data_addr  <= 32'd0;
      r_data_wdata <= 32'd0;
      r_rdata_q    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_killed <= 1'b0;
          if (w_start) begin
            r_state      <= ADDR;
            r_data_req   <= 1'b1;
            r_data_wr    <= m_memwrite;
            r_data_size  <= w_size;
            r_data_addr  <= m_addr;
            r_data_wdata <= w_wdata_rep;
          end
        end
        ADDR: begin
          // The request stays up until accepted, even after a flush; the
          // flushed transaction just has its result dropped later.
          if (m_flush) r_killed <= 1'b1;
          if (dbus.data_addr_ok) begin
            r_data_req <= 1'b0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (dbus.data_data_ok) begin
            // A flush arriving together with data_ok also discards the data.
            if (r_killed || m_flush) begin
              r_killed <= 1'b0;
              r_state  <= IDLE;
            end else begin
              if (!r_data_wr) r_rdata_q <= dbus.data_rdata;
              r_state <= DONE;
            end
          end else if (m_flush) begin
            r_killed <= 1'b1;
          end
        end
        DONE: begin
          // Same instruction still sits in M here, so never re-request.
          if (m_advance || m_flush) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dbus.data_req   = r_data_req;
  assign dbus.data_wr    = r_data_wr;
  assign dbus.data_size  = r_data_size;
  assign dbus.data_addr  = r_data_addr;
  assign dbus.data_wdata = r_data_wdata;
  assign rdata_q         = r_rdata_q;

`ifdef DREQ_PERF_EN
  logic [PERF_W-1:0] r_perf_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_cnt <= '0;
    end else if (m_stall) begin
      r_perf_cnt <= r_perf_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_mem_dreq.sv
// -----------------------------------------------------------------------------
// tb_mem_dreq: directed-vector bench for mem_dreq. The bench plays both the
// pipeline and the data bus, cycle by cycle, with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_dreq;
  import cpu_defs::*;

  logic        clk;
  logic        resetn;
  logic        m_valid;
  logic        m_memread;
  logic        m_memwrite;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_flush;
  logic        m_advance;
  logic        m_stall;
  logic [31:0] rdata_q;
  logic        adel;
  logic        ades;
`ifdef DREQ_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  mem_dreq_if dbus ();

  mem_dreq #(.PERF_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .m_valid        (m_valid),
    .m_memread      (m_memread),
    .m_memwrite     (m_memwrite),
    .m_size         (m_size),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_flush        (m_flush),
    .m_advance      (m_advance),
    .m_stall        (m_stall),
    .rdata_q        (rdata_q),
    .adel           (adel),
    .ades           (ades),
`ifdef DREQ_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .dbus           (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic v, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    m_valid    = v;
    m_memread  = rd;
    m_memwrite = wr;
    m_size     = sz;
    m_addr     = a;
    m_wdata    = wd;
  endtask

  task automatic clear_all();
    set_acc(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    m_flush           = 1'b0;
    m_advance         = 1'b0;
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b0;
    dbus.data_rdata   = 32'd0;
  endtask

  initial begin
    resetn = 1'b0;
    clear_all();
    cyc();
    cyc();
    check("rst req",   dbus.data_req,   32'd0);
    check("rst wr",    dbus.data_wr,    32'd0);
    check("rst size",  dbus.data_size,  32'd0);
    check("rst addr",  dbus.data_addr,  32'd0);
    check("rst wdata", dbus.data_wdata, 32'd0);
    check("rst rdata", rdata_q,         32'd0);
    check("rst stall", m_stall,         32'd0);
`ifdef DREQ_PERF_EN
    check("rst perf",  perf_stall_cnt,  32'd0);
`endif
    resetn = 1'b1;

    // ---- 1: load word 0x1000, addr_ok at once, data_ok two cycles later ----
    cyc();
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'd0);
    #1;
    check("t1 idle stall", m_stall, 32'd1);
    check("t1 idle req", dbus.data_req, 32'd0);
    cyc();
    dbus.data_addr_ok = 1'b1;
    #1;
    check("t1 addr req", dbus.data_req, 32'd1);
    check("t1 addr addr", dbus.data_addr, 32'h0000_1000);
    check("t1 addr wr", dbus.data_wr, 32'd0);
    check("t1 addr size", dbus.data_size, 32'd2);
    check("t1 addr stall", m_stall, 32'd1);
    cyc();
    dbus.data_addr_ok = 1'b0;
    #1;
    check("t1 data1 req", dbus.data_req, 32'd0);
    check("t1 data1 stall", m_stall, 32'd1);
    cyc();
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'hDEAD_BEEF;
    #1;
    check("t1 data2 stall", m_stall, 32'd1);
    cyc();
    dbus.data_data_ok = 1'b0;
    dbus.data_rdata   = 32'd0;
    #1;
    check("t1 done stall", m_stall, 32'd0);
    check("t1 done req", dbus.data_req, 32'd0);
    check("t1 done rdata", rdata_q, 32'hDEAD_BEEF);
    m_advance = 1'b1;
    cyc();
    clear_all();
    #1;
    check("t1 after req", dbus.data_req, 32'd0);
    check("t1 after stall", m_stall, 32'd0);
    $display("txn 1: load word 0x00001000 -> 0x%08h", rdata_q);

    // ---- 2: store byte 0x2003, data 0xA5 ----
    set_acc(1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_2003, 32'h0000_00A5);
    #1;
    check("t2 idle stall", m_stall, 32'd1);
    cyc();
    dbus.data_addr_ok = 1'b1;
    #1;
    check("t2 req", dbus.data_req, 32'd1);
    check("t2 wr", dbus.data_wr, 32'd1);
    check("t2 size", dbus.data_size, 32'd0);
    check("t2 wdata", dbus.data_wdata, 32'hA5A5_A5A5);
    check("t2 addr", dbus.data_addr, 32'h0000_2003);
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    #1;
    check("t2 data stall", m_stall, 32'd1);
    cyc();
    dbus.data_data_ok = 1'b0;
    #1;
    check("t2 done stall", m_stall, 32'd0);
    check("t2 rdata kept", rdata_q, 32'hDEAD_BEEF);
    m_advance = 1'b1;
    cyc();
    clear_all();
    $display("txn 2: store byte 0x00002003 wdata 0xA5A5A5A5");

    // ---- 3: misaligned load half / store word ----
    set_acc(1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_3001, 32'd0);
    #1;
    check("t3 adel", adel, 32'd1);
    check("t3 ades low", ades, 32'd0);
    check("t3 ld stall", m_stall, 32'd0);
    cyc();
    #1;
    check("t3 ld req", dbus.data_req, 32'd0);
    set_acc(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_3002, 32'h1111_2222);
    #1;
    check("t3 ades", ades, 32'd1);
    check("t3 adel low", adel, 32'd0);
    check("t3 st stall", m_stall, 32'd0);
    cyc();
    #1;
    check("t3 st req", dbus.data_req, 32'd0);
    clear_all();
    $display("txn 3: misaligned ld half 0x00003001 / st word 0x00003002, no request");

    // ---- 4: store half 0x4002, addr_ok held low 5 cycles ----
    set_acc(1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_4002, 32'h1234_BEEF);
    #1;
    check("t4 idle stall", m_stall, 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      // Scramble the M-stage fields: the bus must keep the registered copy.
      if (k == 0) begin
        m_addr  = 32'h0000_5000;
        m_wdata = 32'd0;
      end
      #1;
      check("t4 hold req", dbus.data_req, 32'd1);
      check("t4 hold addr", dbus.data_addr, 32'h0000_4002);
      check("t4 hold wdata", dbus.data_wdata, 32'hBEEF_BEEF);
      check("t4 hold size", dbus.data_size, 32'd1);
      check("t4 hold wr", dbus.data_wr, 32'd1);
      check("t4 hold stall", m_stall, 32'd1);
    end
    cyc();
    dbus.data_addr_ok = 1'b1;
    #1;
    check("t4 accept req", dbus.data_req, 32'd1);
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    #1;
    check("t4 data stall", m_stall, 32'd1);
    cyc();
    dbus.data_data_ok = 1'b0;
    #1;
    check("t4 done stall", m_stall, 32'd0);
    m_advance = 1'b1;
    cyc();
    clear_all();
    $display("txn 4: store half 0x00004002 after 5 wait cycles");

    // ---- 5: flush one cycle after addr_ok, data discarded, next load ok ----
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_6000, 32'd0);
    cyc();
    dbus.data_addr_ok = 1'b1;
    cyc();
    dbus.data_addr_ok = 1'b0;
    m_flush = 1'b1;
    #1;
    check("t5 flush stall", m_stall, 32'd1);
    cyc();
    clear_all();
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h1234_5678;
    #1;
    check("t5 killed stall", m_stall, 32'd1);
    check("t5 killed req", dbus.data_req, 32'd0);
    cyc();
    clear_all();
    #1;
    check("t5 discard rdata", rdata_q, 32'hDEAD_BEEF);
    check("t5 no 2nd req", dbus.data_req, 32'd0);
    check("t5 idle stall", m_stall, 32'd0);
    $display("txn 5: flushed load 0x00006000, data discarded");
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_7000, 32'd0);
    #1;
    check("t5 next stall", m_stall, 32'd1);
    cyc();
    dbus.data_addr_ok = 1'b1;
    #1;
    check("t5 next req", dbus.data_req, 32'd1);
    check("t5 next addr", dbus.data_addr, 32'h0000_7000);
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'hCAFE_F00D;
    cyc();
    dbus.data_data_ok = 1'b0;
    #1;
    check("t5 next rdata", rdata_q, 32'hCAFE_F00D);
    check("t5 next done stall", m_stall, 32'd0);
    m_advance = 1'b1;
    cyc();
    clear_all();
    $display("txn 6: load word 0x00007000 -> 0x%08h", rdata_q);

    // ---- 6: flush together with data_ok; flush suppresses start in IDLE ----
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_8000, 32'd0);
    cyc();
    dbus.data_addr_ok = 1'b1;
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h1111_1111;
    m_flush = 1'b1;
    cyc();
    clear_all();
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_8004, 32'd0);
    m_flush = 1'b1;
    #1;
    check("t6 no capture", rdata_q, 32'hCAFE_F00D);
    check("t6 flush-idle stall", m_stall, 32'd0);
    cyc();
    m_flush = 1'b0;
    #1;
    check("t6 flush-idle req", dbus.data_req, 32'd0);
    check("t6 back idle stall", m_stall, 32'd1);
    $display("txn 7: flush with data_ok on load 0x00008000, discarded");
    cyc();
    dbus.data_addr_ok = 1'b1;
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h0BAD_F00D;
    cyc();
    dbus.data_data_ok = 1'b0;
    #1;
    check("t6 rdata", rdata_q, 32'h0BAD_F00D);
    // Leave DONE through a flush rather than m_advance.
    m_flush = 1'b1;
    cyc();
    clear_all();
    $display("txn 8: load word 0x00008004 -> 0x%08h, flushed in DONE", rdata_q);

    // ---- 7: reset asserted mid-DATA ----
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_9000, 32'd0);
    #1;
    check("t7 idle stall", m_stall, 32'd1);
    cyc();
    dbus.data_addr_ok = 1'b1;
    cyc();
    dbus.data_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    check("t7 rst req", dbus.data_req, 32'd0);
    check("t7 rst addr", dbus.data_addr, 32'd0);
    check("t7 rst rdata", rdata_q, 32'd0);
    check("t7 rst idle start", m_stall, 32'd1);
`ifdef DREQ_PERF_EN
    check("t7 rst perf", perf_stall_cnt, 32'd0);
`endif
    clear_all();
    cyc();
    cyc();
    resetn = 1'b1;
    $display("txn 9: load word 0x00009000 aborted by reset");

`ifdef DREQ_PERF_EN
    // ---- 8: two back-to-back loads, 3 stall cycles each ----
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_A000, 32'd0);
    cyc();
    dbus.data_addr_ok = 1'b1;
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h0000_0001;
    cyc();
    dbus.data_data_ok = 1'b0;
    #1;
    check("t8 perf first", perf_stall_cnt, 32'd3);
    m_advance = 1'b1;
    cyc();
    m_advance = 1'b0;
    set_acc(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_A004, 32'd0);
    cyc();
    dbus.data_addr_ok = 1'b1;
    cyc();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h0000_0002;
    cyc();
    dbus.data_data_ok = 1'b0;
    #1;
    check("t8 perf second", perf_stall_cnt, 32'd6);
    check("t8 rdata", rdata_q, 32'h0000_0002);
    m_advance = 1'b1;
    cyc();
    clear_all();
    $display("txn 10: two back-to-back loads, perf_stall_cnt=%0d", perf_stall_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
